imem_loader: RTL
================

Name: imem_loader

Overview:
- Upstream boot stage for the multi-cycle KGP-RISC core.
- Accepts a byte stream (length header followed by program words) over a valid/ready interface and assembles little-endian 32-bit words.
- Writes those words into instruction memory at consecutive word addresses.
- Holds the core in reset (cpu_hold) until the load completes cleanly; cpu_hold drives the core's reset input.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse that begins a load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte when in_valid && in_ready at a rising edge.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  ADDR_W  instruction-memory word address.
- im_wdata  output  32  instruction-memory write data.
- cpu_hold  output  1  1 = core held in reset.
- done  output  1  load completed successfully (sticky).
- err  output  1  length rejected (sticky).

Behaviour:
- Reset (async, reset=0): state IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, err=0, all counters and byte assembler cleared. Asserting reset mid-load aborts immediately; no partial write strobe.
- States: IDLE, LEN_LO, LEN_HI, CHECK, DATA, WRITE, DONE, ERR. All outputs are registered.
- IDLE: in_ready=0. start=1 -> LEN_LO, clear word counter, byte index, im_addr.
- LEN_LO: in_ready=1. Accepted byte -> len[7:0]; go to LEN_HI.
- LEN_HI: in_ready=1. Accepted byte -> len[15:8]; go to CHECK.
- CHECK (one cycle, in_ready=0):
  - len==0 or len > 2**ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA: in_ready=1. Byte k of the current word (k=0..3) goes to word[8k+7:8k], so the first byte is the LSB. After the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle, in_ready=0):
  - im_we=1; im_wdata = assembled word; im_addr = current word index.
  - Next cycle: word index increments.
  - If words written == len -> DONE; else -> DATA.
- Write timing: first word at addr 0; the im_addr increment is registered with the strobe de-assertion.
- DONE: cpu_hold=0, done=1, in_ready=0. Further bytes are not accepted.
- ERR: cpu_hold=1, err=1, in_ready=0.
- start=1 in DONE or ERR:
  - Clears done/err and sets cpu_hold=1 in the same edge.
  - Goes to LEN_LO (reload). The core is re-held before any memory write.
- start=1 in LEN_LO..WRITE is ignored.
- in_valid=0 while in_ready=1: state and byte index hold; no timeout.
- in_data is ignored when in_ready=0 even if in_valid=1; the byte is not consumed.
- Throughput: 4 data cycles + 1 WRITE cycle per word at full valid. Total load latency from start = 1 + 2 + 1 + 5·len cycles to DONE, given continuous valid.
- Address wrap: impossible by construction, since len is capped at 2**ADDR_W. The word counter is ADDR_W+1 bits wide.
- im_we is never asserted outside WRITE.

Test Plan:
- Reset then start; bytes 02 00 | 78 56 34 12 | EF BE AD DE continuous. Required:
  - im_we pulses twice: addr0 = 0x12345678, addr1 = 0xDEADBEEF.
  - done=1 and cpu_hold=0 exactly 14 cycles after start.
- Same stream with in_valid toggling 1/0 every cycle:
  - Identical writes; no byte lost or duplicated.
  - in_ready=0 in WRITE, while in_data=0xFF with in_valid=1 is not consumed.
- Header 00 00 -> err=1, cpu_hold=1, no im_we. Header 01 01 (257) with ADDR_W=8 -> err=1, no im_we.
- Header 00 01 (256 words), incrementing data:
  - Last write at im_addr=0xFF; done=1.
  - Counter does not wrap to write addr 0 again.
- Drive reset=0 after the 2nd data byte of word 1:
  - All outputs immediately at reset values (cpu_hold=1, im_we=0).
  - A fresh start with 01 00 AA BB CC DD writes 0xDDCCBBAA to addr 0.
- From DONE, pulse start: same edge gives cpu_hold=1, done=0. Reload of 1 word succeeds; a start pulse issued mid-load has no effect.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory loader for the KGP-RISC core.
//               Receives a 16-bit little-endian word count followed by the
//               program bytes over a valid/ready byte stream, packs them into
//               little-endian 32-bit words and writes them to consecutive
//               instruction-memory addresses. The core is held in reset
//               (cpu_hold) until a load completes without error.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8    // word-address width; must not exceed 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_CHECK  = 3'd3,
        S_DATA   = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Largest legal word count: the full memory, 2**ADDR_W words.
    localparam logic [16:0] C_MAX_LEN = 17'(1) << ADDR_W;

    state_t            r_state;
    logic [15:0]       r_len;       // requested word count from the header
    logic [ADDR_W:0]   r_wcnt;      // words written so far; one spare bit so 2**ADDR_W fits
    logic [1:0]        r_bidx;      // byte position inside the word being assembled
    logic [23:0]       r_word;      // lower three bytes; the fourth goes straight to im_wdata

    logic              w_accept;
    logic [ADDR_W:0]   w_wcnt_nxt;
    logic              w_last;
    logic              w_len_bad;

    // Handshake, next word count and header validity.
    always_comb begin
        w_accept   = in_valid && in_ready;
        w_wcnt_nxt = r_wcnt + {{ADDR_W{1'b0}}, 1'b1};
        w_last     = (16'(w_wcnt_nxt) == r_len);
        w_len_bad  = (r_len == 16'd0) || ({1'b0, r_len} > C_MAX_LEN);
    end

    // Loader state machine; every output is a register updated with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_len    <= 16'd0;
            r_wcnt   <= '0;
            r_bidx   <= 2'd0;
            r_word   <= 24'd0;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse raised only on WRITE entry.
            im_we <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wcnt   <= '0;
                        r_bidx   <= 2'd0;
                        im_addr  <= '0;
                        in_ready <= 1'b1;
                        r_state  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_state    <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_data;
                        in_ready    <= 1'b0;
                        r_state     <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (w_len_bad) begin
                        err     <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        in_ready <= 1'b1;
                        r_state  <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_bidx <= r_bidx + 2'd1;
                        case (r_bidx)
                            2'd0: r_word[7:0]   <= in_data;
                            2'd1: r_word[15:8]  <= in_data;
                            2'd2: r_word[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word: present it for one write cycle.
                                im_we    <= 1'b1;
                                im_wdata <= {in_data, r_word};
                                in_ready <= 1'b0;
                                r_state  <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_wcnt <= w_wcnt_nxt;
                    if (w_last) begin
                        // Address is left on the final word so it never wraps back to 0.
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        im_addr  <= im_addr + 1'b1;
                        in_ready <= 1'b1;
                        r_state  <= S_DATA;
                    end
                end

                S_DONE, S_ERR: begin
                    // Reload: re-hold the core on the same edge that clears the status.
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        r_wcnt   <= '0;
                        r_bidx   <= 2'd0;
                        im_addr  <= '0;
                        in_ready <= 1'b1;
                        r_state  <= S_LEN_LO;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
